fcu_prefetch: RTL and testbench
===============================

# fcu_prefetch

Parametrised fetch control unit with an instruction prefetch queue. It issues word reads to the BIU and assembles WORDS_PER_INSTR consecutive bus words into one instruction. Completed instructions are buffered in a DEPTH-entry FIFO that the decode/control stage drains with a valid/ready handshake. The block sits between the control unit and the BIU, and adds three things the single-instruction fetch unit lacks: a multi-entry prefetch, a branch flush/redirect, and configurable word, instruction and address widths.

## Interface
- DATA_W, 16, BUS word width.
- ADDR_W, 16, fetch address width (word-addressed).
- WORDS_PER_INSTR, 2, bus words per instruction (≥1).
- DEPTH, 4, prefetch queue entries (power of 2, ≥2).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cs_fcu  in  1  prefetch enable from the control unit.
- flush  in  1  one-cycle redirect request (taken branch or jump).
- flush_addr  in  ADDR_W  new PC, sampled when flush=1.
- instr  out  DATA_W*WORDS_PER_INSTR  queue head; word 0 occupies the most significant slice.
- instr_valid  out  1  queue is non-empty.
- instr_ready  in  1  consumer accepts the head.
- queue_count  out  $clog2(DEPTH+1)  number of complete instructions buffered.
- biu_req  out  1  word read request (chip select to the BIU).
- biu_sel  out  2  2'b11 while biu_req=1 (code fetch), otherwise 2'b00.
- fetch_address  out  ADDR_W  word address of the current request.
- biu_ready  in  1  BIU completes the current word this cycle.
- bus  in  DATA_W  read data, valid when biu_ready=1.

## Operation
- State machine: IDLE, FETCH, FULL.
  - IDLE → FETCH when cs_fcu=1 and count<DEPTH.
  - FETCH → FULL when a push makes count=DEPTH.
  - FETCH → IDLE when cs_fcu=0 at an instruction boundary (word_cnt=0).
  - FULL → FETCH when count<DEPTH and cs_fcu=1.
  - FULL → IDLE when cs_fcu=0.
- Word transfer: a word is accepted on an edge where biu_req=1 and biu_ready=1.
  - bus goes to slice word_cnt. Slice 0 is the MSBs.
  - pc increments by 1, modulo 2^ADDR_W.
  - word_cnt increments.
- Instruction push: when word_cnt reaches WORDS_PER_INSTR-1 and that word is accepted, the assembled instruction is pushed and word_cnt returns to 0.
- New-instruction gating:
  - A new instruction is started only if cs_fcu=1 and the next-cycle count<DEPTH.
  - An instruction already in assembly always completes, even if cs_fcu falls.
- Pop: occurs when instr_valid=1 and instr_ready=1. A push and a pop on the same edge leave count unchanged.
- biu_req, biu_sel and fetch_address are registered.
  - fetch_address equals pc.
  - fetch_address stays stable while biu_req=1 and biu_ready=0.
- Flush:
  - flush has priority over push, pop and word capture.
  - On the flush edge: the queue empties (count=0), the partial instruction and word_cnt are cleared, and pc becomes flush_addr.
  - A word accepted on the flush edge is discarded.
  - The state moves to FETCH if cs_fcu=1, otherwise to IDLE.
- Queue read and write pointers wrap modulo DEPTH.

## Timing
- While reset=0, asynchronously:
  - state=IDLE, pc=RESET_PC, fetch_address=RESET_PC.
  - word_cnt=0, count=0.
  - biu_req=0, biu_sel=2'b00.
  - instr_valid=0, instr=0, queue_count=0.
- From IDLE with cs_fcu=1 sampled at edge E0, biu_req=1 after E0.
  - With biu_ready held at 1, words are accepted at E1..E(WORDS_PER_INSTR).
  - instr_valid=1 after edge E(WORDS_PER_INSTR). For the default parameters that is E2.
- Sustained throughput: one instruction per WORDS_PER_INSTR cycles while the queue is not full and biu_ready=1.
- biu_req falls on the same edge as the push that fills the queue. No word is requested with nowhere to go.
- After a flush at edge F, biu_req=1 with fetch_address=flush_addr after F+1 (only if cs_fcu=1).
- instr and queue_count update on the edge after a push or pop. instr is the head entry, undefined-free: it is 0 when empty after reset or flush.

## Test plan
- Reset asserted mid-FETCH with biu_req=1:
  - Outputs return immediately to the reset values listed above.
  - After release with cs_fcu=1, the first fetch_address is 0x0000.
- Fill, defaults: biu_ready=1, bus=fetch_address+0x1000, instr_ready=0.
  - Exactly 8 words are accepted and queue_count=4.
  - biu_req=0 and fetch_address=0x0008.
  - instr=0x1000_1001.
- BIU wait states: hold biu_ready=0 for 3 cycles during the second word.
  - fetch_address is held at 0x0001 and no capture occurs.
  - instr_valid rises one edge after biu_ready returns to 1.
- Flush with flush_addr=0x0040 on an edge where the queue holds 2 instructions, word 0 is pending, and biu_ready=1.
  - queue_count=0 and instr_valid=0.
  - The captured word is discarded.
  - The next request is at 0x0040, and the next head comes from 0x0040/0x0041.
- Simultaneous push and pop at count=3 → count stays 3, and the head advances to the next instruction.
- RESET_PC=0xFFFE, then drop cs_fcu after the first word of an instruction.
  - That instruction completes from 0xFFFE/0xFFFF.
  - pc wraps to 0x0000.
  - biu_req stays 0 and the state is IDLE.

Source files
------------

// File: rtl/fcu_prefetch.sv
// Fetch control unit: assembles WORDS_PER_INSTR bus words per instruction and buffers them
// in a DEPTH-entry prefetch queue, with branch flush/redirect.
module fcu_prefetch #(
    parameter int                DATA_W          = 16,
    parameter int                ADDR_W          = 16,
    parameter int                WORDS_PER_INSTR = 2,
    parameter int                DEPTH           = 4,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                cs_fcu,
    input  logic                                flush,
    input  logic [ADDR_W-1:0]                   flush_addr,
    output logic [DATA_W*WORDS_PER_INSTR-1:0]   instr,
    output logic                                instr_valid,
    input  logic                                instr_ready,
    output logic [$clog2(DEPTH+1)-1:0]          queue_count,
    output logic                                biu_req,
    output logic [1:0]                          biu_sel,
    output logic [ADDR_W-1:0]                   fetch_address,
    input  logic                                biu_ready,
    input  logic [DATA_W-1:0]                   bus
);
    localparam int IW    = DATA_W * WORDS_PER_INSTR;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int WC_W  = (WORDS_PER_INSTR > 1) ? $clog2(WORDS_PER_INSTR) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

    state_t                             state_q, state_d;
    logic [ADDR_W-1:0]                  pc_q, pc_d;
    logic [WC_W-1:0]                    word_cnt_q, word_cnt_d;
    logic [0:WORDS_PER_INSTR-1][DATA_W-1:0] asm_q, asm_d, asm_next;
    logic [CNT_W-1:0]                   count_q, count_d;
    logic [PTR_W-1:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                               biu_req_q, biu_req_d;
    logic [1:0]                         biu_sel_q, biu_sel_d;
    logic [IW-1:0]                      mem_q [DEPTH];
    logic                               accept, last_word, push, pop;

    always_comb begin
        accept    = biu_req_q && biu_ready;
        last_word = (word_cnt_q == WC_W'(WORDS_PER_INSTR - 1));
        // Slice 0 is the most significant word of the instruction
        asm_next  = asm_q;
        asm_next[word_cnt_q] = bus;
        push      = accept && last_word && !flush;
        pop       = (count_q != '0) && instr_ready && !flush;

        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);

        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        pc_d       = accept ? pc_q + ADDR_W'(1) : pc_q;
        asm_d      = accept ? asm_next : asm_q;
        word_cnt_d = word_cnt_q;
        if (accept) word_cnt_d = last_word ? '0 : word_cnt_q + WC_W'(1);

        if (flush) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pc_d       = flush_addr;
            asm_d      = '0;
            word_cnt_d = '0;
        end

        // A partial instruction always finishes; a new one needs cs_fcu and a free slot
        biu_req_d = !flush && ((word_cnt_d != '0) || (cs_fcu && count_d < CNT_W'(DEPTH)));
        biu_sel_d = biu_req_d ? 2'b11 : 2'b00;

        state_d = state_q;
        if (flush) begin
            state_d = cs_fcu ? FETCH : IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cs_fcu && count_q < CNT_W'(DEPTH)) state_d = FETCH;
                FETCH: begin
                    if (push && count_d == CNT_W'(DEPTH))      state_d = FULL;
                    else if (!cs_fcu && word_cnt_d == '0)      state_d = IDLE;
                end
                FULL: begin
                    if (!cs_fcu)                               state_d = IDLE;
                    else if (count_q < CNT_W'(DEPTH))          state_d = FETCH;
                end
                default:                                       state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            word_cnt_q <= '0;
            asm_q      <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            biu_req_q  <= 1'b0;
            biu_sel_q  <= 2'b00;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            biu_req_q  <= biu_req_d;
            biu_sel_q  <= biu_sel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= asm_next;
    end

    assign instr_valid   = (count_q != '0);
    assign instr         = instr_valid ? mem_q[rd_ptr_q] : '0;
    assign queue_count   = count_q;
    assign fetch_address = pc_q;
    assign biu_req       = biu_req_q;
    assign biu_sel       = biu_sel_q;
endmodule

// File: tb/tb_fcu_prefetch.sv
// Directed bench for fcu_prefetch: scoreboard of expected instructions checked on every pop,
// plus direct checks of reset, fill, wait-state, flush, push/pop and pc-wrap behaviour.
module tb_fcu_prefetch;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs_fcu = 1'b0, flush = 1'b0, instr_ready = 1'b0, biu_ready = 1'b1;
    logic [15:0] flush_addr = '0;
    logic [31:0] instr;
    logic        instr_valid, biu_req;
    logic [2:0]  queue_count;
    logic [1:0]  biu_sel;
    logic [15:0] fetch_address, bus;

    logic        cs2 = 1'b0;
    logic [31:0] instr2;
    logic        instr_valid2, biu_req2;
    logic [2:0]  queue_count2;
    logic [1:0]  biu_sel2;
    logic [15:0] fetch_address2, bus2;

    int ncmp = 0, nfail = 0, words = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;
    assign bus  = fetch_address + 16'h1000;
    assign bus2 = fetch_address2 + 16'h1000;

    fcu_prefetch dut (
        .clk(clk), .reset(reset), .cs_fcu(cs_fcu), .flush(flush), .flush_addr(flush_addr),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .queue_count(queue_count), .biu_req(biu_req), .biu_sel(biu_sel),
        .fetch_address(fetch_address), .biu_ready(biu_ready), .bus(bus)
    );

    fcu_prefetch #(.RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .reset(reset), .cs_fcu(cs2), .flush(1'b0), .flush_addr(16'h0000),
        .instr(instr2), .instr_valid(instr_valid2), .instr_ready(1'b0),
        .queue_count(queue_count2), .biu_req(biu_req2), .biu_sel(biu_sel2),
        .fetch_address(fetch_address2), .biu_ready(1'b1), .bus(bus2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every accepted head must match the oldest expected instruction
    always @(negedge clk) begin
        if (reset && biu_req && biu_ready) words++;
        if (reset && instr_valid && instr_ready) begin
            ncmp++;
            if (exp_q.size() == 0) begin
                nfail++;
                $display("FAIL scoreboard_unexpected: got %h expected none", instr);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (instr !== e) begin
                    nfail++;
                    $display("FAIL scoreboard_pop: got %h expected %h", instr, e);
                end
            end
        end
    end

    initial begin
        int w0;
        // Reset values
        tick(2);
        chk("rst_biu_req", biu_req, 0);
        chk("rst_biu_sel", biu_sel, 0);
        chk("rst_fetch_address", fetch_address, 0);
        chk("rst_queue_count", queue_count, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_fetch_address2", fetch_address2, 16'hFFFE);

        // Reset asserted mid-fetch
        reset = 1'b1; cs_fcu = 1'b1;
        tick(2);
        chk("midfetch_req_before", biu_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_biu_req", biu_req, 0);
        chk("async_rst_biu_sel", biu_sel, 0);
        chk("async_rst_fetch_address", fetch_address, 0);
        chk("async_rst_instr_valid", instr_valid, 0);
        tick(1);
        reset = 1'b1;

        // Fill with defaults
        exp_q.push_back(32'h1000_1001);
        exp_q.push_back(32'h1002_1003);
        exp_q.push_back(32'h1004_1005);
        exp_q.push_back(32'h1006_1007);
        tick(1);
        chk("first_req", biu_req, 1);
        chk("first_fetch_address", fetch_address, 0);
        chk("first_biu_sel", biu_sel, 2'b11);
        words = 0;
        tick(2);
        chk("latency_valid", instr_valid, 1);
        chk("latency_count", queue_count, 1);
        tick(6);
        chk("fill_count", queue_count, 4);
        chk("fill_biu_req", biu_req, 0);
        chk("fill_biu_sel", biu_sel, 0);
        chk("fill_fetch_address", fetch_address, 16'h0008);
        chk("fill_instr", instr, 32'h1000_1001);
        tick(2);
        chk("fill_words", words, 8);

        // Pop one, then simultaneous push and pop at count 3
        exp_q.push_back(32'h1008_1009);
        instr_ready = 1'b1;
        tick(1);
        instr_ready = 1'b0;
        chk("pop_refetch_req", biu_req, 1);
        chk("pop_count", queue_count, 3);
        tick(1);
        instr_ready = 1'b1;
        tick(1);
        instr_ready = 1'b0;
        chk("pushpop_count", queue_count, 3);
        chk("pushpop_head", instr, 32'h1004_1005);
        exp_q.push_back(32'h100A_100B);
        tick(2);
        chk("refill_count", queue_count, 4);
        chk("refill_fetch_address", fetch_address, 16'h000C);

        // Flush with two queued instructions and word 0 being accepted
        biu_ready = 1'b0; instr_ready = 1'b1;
        tick(2);
        chk("preflush_count", queue_count, 2);
        instr_ready = 1'b0; biu_ready = 1'b1;
        flush = 1'b1; flush_addr = 16'h0040;
        exp_q.delete();
        tick(1);
        flush = 1'b0;
        chk("flush_count", queue_count, 0);
        chk("flush_valid", instr_valid, 0);
        chk("flush_instr", instr, 0);
        tick(1);
        chk("postflush_req", biu_req, 1);
        chk("postflush_addr", fetch_address, 16'h0040);
        exp_q.push_back(32'h1040_1041);
        tick(1);
        cs_fcu = 1'b0;
        tick(1);
        chk("postflush_head", instr, 32'h1040_1041);
        chk("postflush_qcount", queue_count, 1);
        chk("csoff_req", biu_req, 0);
        instr_ready = 1'b1;
        tick(1);
        instr_ready = 1'b0;
        chk("drained_count", queue_count, 0);

        // Wait states during the second word
        reset = 1'b0;
        tick(1);
        reset = 1'b1; cs_fcu = 1'b1;
        tick(2);
        biu_ready = 1'b0;
        w0 = words;
        tick(3);
        chk("wait_fetch_address", fetch_address, 16'h0001);
        chk("wait_no_capture", words, w0);
        chk("wait_valid", instr_valid, 0);
        biu_ready = 1'b1; cs_fcu = 1'b0;
        exp_q.push_back(32'h1000_1001);
        tick(1);
        chk("wait_valid_rise", instr_valid, 1);
        chk("wait_instr", instr, 32'h1000_1001);
        instr_ready = 1'b1;
        tick(1);
        instr_ready = 1'b0;

        // pc wrap with cs dropped after the first word
        cs2 = 1'b1;
        tick(1);
        chk("wrap_first_addr", fetch_address2, 16'hFFFE);
        tick(1);
        cs2 = 1'b0;
        tick(1);
        chk("wrap_instr", instr2, 32'h0FFE_0FFF);
        chk("wrap_count", queue_count2, 1);
        chk("wrap_pc", fetch_address2, 16'h0000);
        tick(3);
        chk("wrap_idle_req", biu_req2, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
